skip_buffer: RTL

//  Captures one encoder stage's pre-pool skip stream (skip_out/skip_valid) into on-chip RAM.

---
 rtl/skip_buffer_pkg.sv | 21 ++
 rtl/skip_buffer_if.sv | 28 ++
 rtl/skip_buffer_ram.sv | 34 +++
 rtl/skip_buffer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/skip_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : skip_buffer_pkg
//  Brief    : Shared types and constants for the skip-connection frame buffer
//  Revision : 1.0 - initial release
// ============================================================================
package skip_buffer_pkg;

    localparam int c_STATE_W    = 2;
    localparam int c_SKID_DEPTH = 2;
    localparam int c_SKID_CNT_W = $clog2(c_SKID_DEPTH + 1);

    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HOLD    = 2'd2,
        ST_REPLAY  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/skip_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : skip_buffer_if
//  Brief    : Capture stream plus valid/ready replay stream of the skip buffer
//  Revision : 1.0 - initial release
// ============================================================================
interface skip_buffer_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_ready;

    // Encoder/decoder side: drives the capture stream, consumes the replay
    modport master (
        output wr_data, wr_valid, rd_ready,
        input  rd_data, rd_valid
    );

    // Buffer side
    modport slave (
        input  wr_data, wr_valid, rd_ready,
        output rd_data, rd_valid
    );
endinterface
`default_nettype wire

// File: rtl/skip_buffer_ram.sv
`default_nettype none
// ============================================================================
//  Module   : skip_buffer_ram
//  Brief    : Simple dual-port RAM, one write port, one synchronous read port
//  Revision : 1.0 - initial release
// ============================================================================
module skip_buffer_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  wire                  clk,
    input  wire                  wr_en,
    input  wire [ADDR_WIDTH-1:0] wr_addr,
    input  wire [DATA_WIDTH-1:0] wr_data,
    input  wire                  rd_en,
    input  wire [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Write port and 1-cycle registered read port; storage has no reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= r_mem[rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/skip_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : skip_buffer
//  Brief    : Captures one encoder skip frame into RAM and replays it, in
//             capture order, to the decoder over a valid/ready handshake
//  Revision : 1.0 - initial release
// ============================================================================
module skip_buffer
    import skip_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_HEIGHT = 8,
    parameter int IMG_WIDTH  = 8,
    parameter int CHANNELS   = 4,
    localparam int c_FRAME_LEN = IMG_HEIGHT * IMG_WIDTH * CHANNELS,
    localparam int c_ADDR_W    = $clog2(c_FRAME_LEN)
) (
    input  wire                 clk,
    input  wire                 rst,
    input  wire                 start,
    input  wire                 replay_start,
    skip_buffer_if.slave        bus,
    output logic                capture_done,
    output logic                replay_done,
    output logic                overflow,
    output logic [c_ADDR_W:0]   wr_count
);

    localparam logic [c_ADDR_W:0]   c_LAST_WR = (c_ADDR_W + 1)'(c_FRAME_LEN - 1);
    localparam logic [c_ADDR_W-1:0] c_LAST_RD = c_ADDR_W'(c_FRAME_LEN - 1);
    localparam int                  c_OCC_W   = c_SKID_CNT_W + 1;

    state_t                  r_state;
    logic [c_ADDR_W:0]       r_wr_count;     // doubles as the write pointer
    logic [c_ADDR_W-1:0]     r_rd_ptr;
    logic                    r_issue_done;   // every address of the frame has been read
    logic                    r_inflight;     // RAM read data lands in the skid next edge
    logic [c_SKID_CNT_W-1:0] r_skid_cnt;
    logic [DATA_WIDTH-1:0]   r_skid0;        // head entry, drives rd_data
    logic [DATA_WIDTH-1:0]   r_skid1;
    logic                    r_capture_done;
    logic                    r_replay_done;
    logic                    r_overflow;

    logic                    w_we;
    logic                    w_replay_go;
    logic                    w_pop;
    logic [c_OCC_W-1:0]      w_occ;
    logic                    w_issue;
    logic [c_ADDR_W-1:0]     w_rd_addr;
    logic                    w_last_rd;
    logic                    w_push_to_1;
    logic [DATA_WIDTH-1:0]   w_ram_q;

    // A start pulse pre-empts everything, including a write or replay request
    // in the same cycle.
    assign w_we        = (r_state == ST_CAPTURE) && bus.wr_valid && !start;
    assign w_replay_go = (r_state == ST_HOLD) && replay_start && !start;
    assign w_pop       = (r_skid_cnt != '0) && bus.rd_ready;

    // Occupancy the skid will have after this edge if no new read is issued;
    // the first read goes out in the replay_start cycle itself so rd_valid
    // appears two cycles later.
    assign w_occ     = {1'b0, r_skid_cnt} + c_OCC_W'(r_inflight) - c_OCC_W'(w_pop);
    assign w_issue   = !start && (w_replay_go ||
                       ((r_state == ST_REPLAY) && !r_issue_done &&
                        (w_occ < c_OCC_W'(c_SKID_DEPTH))));
    assign w_rd_addr = w_replay_go ? '0 : r_rd_ptr;

    // Final handshake: nothing left to read, nothing in flight, one word left
    assign w_last_rd = (r_state == ST_REPLAY) && w_pop && r_issue_done &&
                       !r_inflight && (r_skid_cnt == c_SKID_CNT_W'(1));

    // Incoming RAM word goes to entry 1 when entry 0 stays occupied
    assign w_push_to_1 = (r_skid_cnt == c_SKID_CNT_W'(2)) ||
                         ((r_skid_cnt == c_SKID_CNT_W'(1)) && !w_pop);

    skip_buffer_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (c_FRAME_LEN),
        .ADDR_WIDTH (c_ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (w_we),
        .wr_addr (r_wr_count[c_ADDR_W-1:0]),
        .wr_data (bus.wr_data),
        .rd_en   (w_issue),
        .rd_addr (w_rd_addr),
        .rd_data (w_ram_q)
    );

    // Control FSM with capture/replay pointers and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_wr_count     <= '0;
            r_rd_ptr       <= '0;
            r_issue_done   <= 1'b0;
            r_capture_done <= 1'b0;
            r_replay_done  <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            r_replay_done <= 1'b0;
            if (start) begin
                r_state        <= ST_CAPTURE;
                r_wr_count     <= '0;
                r_rd_ptr       <= '0;
                r_issue_done   <= 1'b0;
                r_capture_done <= 1'b0;
                r_overflow     <= 1'b0;
            end else begin
                if (bus.wr_valid && (r_state != ST_CAPTURE)) begin
                    r_overflow <= 1'b1;
                end
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_IDLE;
                    end
                    ST_CAPTURE: begin
                        if (w_we) begin
                            r_wr_count <= r_wr_count + 1'b1;
                            if (r_wr_count == c_LAST_WR) begin
                                r_state        <= ST_HOLD;
                                r_capture_done <= 1'b1;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (w_replay_go) begin
                            r_state      <= ST_REPLAY;
                            r_issue_done <= 1'b0;
                        end
                    end
                    ST_REPLAY: begin
                        if (w_last_rd) begin
                            r_state       <= ST_HOLD;
                            r_replay_done <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
                // Read pointer stops on the last address instead of wrapping
                if (w_issue) begin
                    if (w_rd_addr == c_LAST_RD) begin
                        r_issue_done <= 1'b1;
                    end else begin
                        r_rd_ptr <= w_rd_addr + 1'b1;
                    end
                end
            end
        end
    end

    // Two-entry output skid fed by the RAM read port; start flushes it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_skid_cnt <= '0;
            r_inflight <= 1'b0;
            r_skid0    <= '0;
            r_skid1    <= '0;
        end else if (start) begin
            r_skid_cnt <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_skid_cnt <= r_skid_cnt + c_SKID_CNT_W'(r_inflight) - c_SKID_CNT_W'(w_pop);
            if (w_pop) begin
                r_skid0 <= r_skid1;
            end
            if (r_inflight) begin
                if (w_push_to_1) begin
                    r_skid1 <= w_ram_q;
                end else begin
                    r_skid0 <= w_ram_q;
                end
            end
        end
    end

    assign bus.rd_data  = r_skid0;
    assign bus.rd_valid = (r_skid_cnt != '0);
    assign capture_done = r_capture_done;
    assign replay_done  = r_replay_done;
    assign overflow     = r_overflow;
    assign wr_count     = r_wr_count;

endmodule
`default_nettype wire
